mulu_m7q7_sequencer: RTL and testbench



---
 rtl/mulu_m7q7_sequencer_pkg.sv | 17 +
 rtl/mulu_m7q7_sequencer_if.sv | 25 ++
 rtl/mulu_m7q7_sequencer_shift_add.sv | 59 +++++
 rtl/mulu_m7q7_sequencer.sv | 153 +++++++++++++++
 tb/tb_mulu_m7q7_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mulu_m7q7_sequencer_pkg.sv
// Shared definitions for the 7x7 multiplier load/unload sequencer:
// operand width default, nibble geometry and FSM state encoding.
package mulu_m7q7_sequencer_pkg;

  localparam int unsigned OP_W_DEF = 7;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned NIB_CNT  = 4;
  localparam int unsigned CNT_W    = $clog2(NIB_CNT);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_MUL    = 2'd1,
    ST_RES_LO = 2'd2,
    ST_RES_HI = 2'd3
  } state_t;

endpackage

// File: rtl/mulu_m7q7_sequencer_if.sv
// Host-facing pin bundle of the sequencer: nibble load strobe/data,
// result-advance strobe and the product-half output.
interface mulu_m7q7_sequencer_if
  import mulu_m7q7_sequencer_pkg::*;
#(
  parameter int unsigned OP_W = OP_W_DEF
);

  logic             in_strobe;
  logic [NIB_W-1:0] in_nib;
  logic             out_next;
  logic             out_valid;
  logic [OP_W-1:0]  out_data;

  modport master (
    output in_strobe, in_nib, out_next,
    input  out_valid, out_data
  );

  modport slave (
    input  in_strobe, in_nib, out_next,
    output out_valid, out_data
  );

endinterface

// File: rtl/mulu_m7q7_sequencer_shift_add.sv
// Iterative unsigned shift-add multiplier: start loads the operands, then
// one partial product per cycle, LSB-first on b, for exactly W cycles.
// last_c flags the cycle whose edge commits the final step; p_next_c is the
// value p takes at that edge, so the caller can register it without delay.
module mulu_m7q7_sequencer_shift_add #(
  parameter int unsigned W = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p,
  output logic [2*W-1:0] p_next_c,
  output logic           last_c
);

  localparam int unsigned IW = $clog2(W);

  logic           busy;
  logic [IW-1:0]  iter;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;

  // Accumulate the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    p_next_c = p;
    if (busy && mplier[0]) begin
      p_next_c = p + mcand;
    end
    last_c = busy && (iter == IW'(W - 1));
  end

  // Operand shift registers, iteration counter and product accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      iter   <= '0;
      mcand  <= '0;
      mplier <= '0;
      p      <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      iter   <= '0;
      mcand  <= (2*W)'(a);
      mplier <= b;
      p      <= '0;
    end else if (busy) begin
      p      <= p_next_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      iter   <= iter + IW'(1);
      if (last_c) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mulu_m7q7_sequencer.sv
// Operand-load / result-unload sequencer for the 7x7 unsigned multiplier.
// Four strobed nibbles load A then B, a shift-add core runs OP_W cycles,
// and the product is unloaded as low then high OP_W-bit halves.
// Optional macro MULSEQ_INPUT_SYNC_EN: 2-flop synchronizers on in_strobe and
// out_next ahead of the edge detectors (default: pins feed edge detect directly).
module mulu_m7q7_sequencer
  import mulu_m7q7_sequencer_pkg::*;
#(
  parameter int unsigned OP_W = OP_W_DEF
) (
  input logic                  clk,
  input logic                  rst,
  mulu_m7q7_sequencer_if.slave bus
);

  localparam int unsigned PROD_W = 2 * OP_W;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [OP_W-1:0]    a_reg, a_d;
  logic [NIB_W-1:0]   b_lo, b_lo_d;
  logic               out_valid_d;
  logic [OP_W-1:0]    out_data_d;
  logic               start_c;
  logic [OP_W-1:0]    b_full_c;
  logic [PROD_W-1:0]  prod, prod_next_c;
  logic               last_c;
  logic               strobe_lvl_c, next_lvl_c;
  logic               strobe_prev, next_prev;
  logic               strobe_evt_c, next_evt_c;

`ifdef MULSEQ_INPUT_SYNC_EN
  logic [1:0] strobe_sync, next_sync;

  // Two-flop synchronizers for the asynchronous host strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_sync <= '0;
      next_sync   <= '0;
    end else begin
      strobe_sync <= {strobe_sync[0], bus.in_strobe};
      next_sync   <= {next_sync[0], bus.out_next};
    end
  end

  assign strobe_lvl_c = strobe_sync[1];
  assign next_lvl_c   = next_sync[1];
`else
  assign strobe_lvl_c = bus.in_strobe;
  assign next_lvl_c   = bus.out_next;
`endif

  // Previous strobe levels for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_prev <= 1'b0;
      next_prev   <= 1'b0;
    end else begin
      strobe_prev <= strobe_lvl_c;
      next_prev   <= next_lvl_c;
    end
  end

  assign strobe_evt_c = strobe_lvl_c & ~strobe_prev;
  assign next_evt_c   = next_lvl_c & ~next_prev;

  // B is only complete on the edge that captures its high nibble; bit 3 of that nibble drops out
  assign b_full_c = OP_W'({bus.in_nib, b_lo});

  mulu_m7q7_sequencer_shift_add #(
    .W (OP_W)
  ) u_shift_add (
    .clk      (clk),
    .rst      (rst),
    .start    (start_c),
    .a        (a_reg),
    .b        (b_full_c),
    .p        (prod),
    .p_next_c (prod_next_c),
    .last_c   (last_c)
  );

  // State, operand and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_LOAD;
      cnt           <= '0;
      a_reg         <= '0;
      b_lo          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      a_reg         <= a_d;
      b_lo          <= b_lo_d;
      bus.out_valid <= out_valid_d;
      bus.out_data  <= out_data_d;
    end
  end

  // Next-state, nibble capture and output mux; each state honours only its own strobe
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    a_d         = a_reg;
    b_lo_d      = b_lo;
    start_c     = 1'b0;
    out_valid_d = bus.out_valid;
    out_data_d  = bus.out_data;
    case (state)
      ST_LOAD: begin
        if (strobe_evt_c) begin
          cnt_d = cnt + CNT_W'(1);
          case (cnt)
            CNT_W'(0): a_d    = {a_reg[OP_W-1:NIB_W], bus.in_nib};
            CNT_W'(1): a_d    = OP_W'({bus.in_nib, a_reg[NIB_W-1:0]});
            CNT_W'(2): b_lo_d = bus.in_nib;
            default: begin
              start_c = 1'b1;
              state_d = ST_MUL;
            end
          endcase
        end
      end
      ST_MUL: begin
        if (last_c) begin
          state_d     = ST_RES_LO;
          out_valid_d = 1'b1;
          out_data_d  = prod_next_c[OP_W-1:0];
        end
      end
      ST_RES_LO: begin
        if (next_evt_c) begin
          state_d    = ST_RES_HI;
          out_data_d = prod[PROD_W-1:OP_W];
        end
      end
      ST_RES_HI: begin
        if (next_evt_c) begin
          state_d     = ST_LOAD;
          cnt_d       = '0;
          out_valid_d = 1'b0;
          out_data_d  = '0;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_mulu_m7q7_sequencer.sv
// Scoreboard bench for mulu_m7q7_sequencer: the driver pushes the expected
// low/high halves and valid-rise cycle of every load, a negedge monitor pops
// and compares them when out_valid rises and falls.
module tb_mulu_m7q7_sequencer;
  import mulu_m7q7_sequencer_pkg::*;

  localparam int unsigned W = OP_W_DEF;
`ifdef MULSEQ_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int lo;
    int hi;
    int rise;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];

  mulu_m7q7_sequencer_if #(.OP_W(W)) bus ();

  mulu_m7q7_sequencer #(.OP_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: low half and latency on valid rise, last high half and idle data on fall
  logic prev_valid = 1'b0;
  int   last_data = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && prev_valid == 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        check("valid_rise_cycle", cyc, sb[0].rise);
        check("lo_half", int'(bus.out_data), sb[0].lo);
      end
    end
    if (bus.out_valid !== 1'b1 && prev_valid == 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_drop", 1, 0);
      end else begin
        cur = sb.pop_front();
        check("hi_half", last_data, cur.hi);
        check("idle_data", int'(bus.out_data), 0);
      end
    end
    if (bus.out_valid === 1'b1) last_data = int'(bus.out_data);
    prev_valid = (bus.out_valid === 1'b1);
  end

  task automatic send_nib(input logic [3:0] nib, input int hold, input bit push,
                          input int lo, input int hi);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_nib    = nib;
    bus.in_strobe = 1'b1;
    if (push) begin
      e.lo   = lo;
      e.hi   = hi;
      e.rise = cyc + 8 + LAT;
      sb.push_back(e);
    end
    repeat (hold) @(posedge clk);
    #1 bus.in_strobe = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic load(input logic [3:0] n0, input logic [3:0] n1, input logic [3:0] n2,
                      input logic [3:0] n3, input bit push, input int lo, input int hi,
                      input int hold_first, input int hold_last);
    send_nib(n0, hold_first, 1'b0, 0, 0);
    send_nib(n1, 2, 1'b0, 0, 0);
    send_nib(n2, 2, 1'b0, 0, 0);
    send_nib(n3, hold_last, push, lo, hi);
  endtask

  task automatic pulse_next(input bit with_strobe);
    @(posedge clk);
    #1;
    bus.out_next = 1'b1;
    if (with_strobe) begin
      bus.in_nib    = 4'h9;
      bus.in_strobe = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    bus.out_next  = 1'b0;
    bus.in_strobe = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_valid(input logic v, input string name);
    int n = 0;
    while (bus.out_valid !== v && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, int'(bus.out_valid === v), 1);
  endtask

  task automatic unload();
    wait_valid(1'b1, "wait_result");
    pulse_next(1'b0);
    pulse_next(1'b0);
    wait_valid(1'b0, "wait_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_strobe = 1'b0;
    bus.in_nib    = 4'h0;
    bus.out_next  = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_data", int'(bus.out_data), 0);
    rst = 1'b0;

    // 5 * 3 = 15
    load(4'h5, 4'h0, 4'h3, 4'h0, 1'b1, 15, 0, 2, 2);
    unload();

    // 127 * 127 = 16129 = 126*128 + 1, bit 3 of high nibbles dropped
    load(4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1, 126, 2, 2);
    unload();

    // 0 * 100 = 0, valid still asserted for both halves
    load(4'h0, 4'h0, 4'h4, 4'h6, 1'b1, 0, 0, 2, 2);
    unload();

    // 3 * 4 = 12 with stray strobes in MUL and RES_LO, and a simultaneous strobe+next
    load(4'h3, 4'h0, 4'h4, 4'h0, 1'b1, 12, 0, 2, 2);
    send_nib(4'h9, 2, 1'b0, 0, 0);
    wait_valid(1'b1, "wait_result_ign");
    send_nib(4'h9, 2, 1'b0, 0, 0);
    pulse_next(1'b1);
    pulse_next(1'b0);
    wait_valid(1'b0, "wait_idle_ign");
    // next load must start again at nibble 0: 6 * 7 = 42
    load(4'h6, 4'h0, 4'h7, 4'h0, 1'b1, 42, 0, 2, 2);
    unload();

    // reset a few cycles into MUL discards the run
    load(4'h7, 4'h0, 4'h7, 4'h0, 1'b0, 0, 0, 2, 2);
    #1 rst = 1'b1;
    #1;
    check("mul_rst_valid", int'(bus.out_valid), 0);
    check("mul_rst_data", int'(bus.out_data), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("no_result_after_rst", int'(bus.out_valid), 0);
    // 2 * 2 = 4
    load(4'h2, 4'h0, 4'h2, 4'h0, 1'b1, 4, 0, 2, 2);
    unload();

    // strobes held high 10 cycles count once: 3 * 3 = 9
    load(4'h3, 4'h0, 4'h3, 4'h0, 1'b1, 9, 0, 10, 10);
    unload();

    // asynchronous reset while the low half is presented: 5 * 5 = 25
    load(4'h5, 4'h0, 4'h5, 4'h0, 1'b1, 25, 25, 2, 2);
    wait_valid(1'b1, "wait_result_rst");
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("res_rst_valid", int'(bus.out_valid), 0);
    check("res_rst_data", int'(bus.out_data), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // A = 10+16 = 26, B = 11+16 = 27, P = 702 = 5*128 + 62
    load(4'hA, 4'h1, 4'hB, 4'h1, 1'b1, 62, 5, 2, 2);
    unload();

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
